vm_multi_item: RTL

- Parametrised vending-machine controller with configurable item count, price/balance widths and per-item stock tracking.
- Prices and stock are loaded in a configuration burst. Coins are accumulated, then a buy or return decision is resolved.
- Results are streamed on a serial output window: purchased item, greedy change breakdown (50/20/10/5/1), then per-item sales counters.
- Successor of the fixed 6-item controller. Adds sold-out rejection, invalid-index rejection, balance saturation and a parametrised output window.

---
 rtl/vm_pkg.sv | 23 ++
 rtl/vm_change_gen.sv | 51 +++++
 rtl/vm_multi_item.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared types and constants for the multi-item vending-machine controller.
package vm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG,
      ST_COIN,
      ST_DECIDE,
      ST_OUT
   } state_e;

   localparam int unsigned COIN_W    = 6;
   localparam int unsigned NUM_DENOM = 5;

   // Greedy change order, largest first
   localparam logic [COIN_W-1:0] DENOM [NUM_DENOM] = '{6'd50, 6'd20, 6'd10, 6'd5, 6'd1};

   function automatic logic is_legal_coin(input logic [COIN_W-1:0] coin);
      return (coin == 6'd1) || (coin == 6'd5) || (coin == 6'd10) ||
             (coin == 6'd20) || (coin == 6'd50);
   endfunction

endpackage

// File: rtl/vm_change_gen.sv
// Greedy change breakdown: holds the residue and yields one denomination count per step.
module vm_change_gen
   import vm_pkg::*;
#(
   parameter int unsigned BAL_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [BAL_W-1:0] i_value,
   input  logic             i_step,
   input  logic [2:0]       i_idx,
   output logic [BAL_W-1:0] o_count_c
);

   localparam int unsigned WIDE_W = 2 * BAL_W;

   logic [BAL_W-1:0]  r_res;
   logic [BAL_W-1:0]  w_rem;
   logic [BAL_W-1:0]  w_quo;
   logic [WIDE_W-1:0] w_trial;
   logic [COIN_W-1:0] w_denom;

   // Restoring compare/subtract of the residue by the selected denomination
   always_comb begin
      w_denom = (i_idx < 3'(NUM_DENOM)) ? DENOM[i_idx] : '0;
      w_rem   = r_res;
      w_quo   = '0;
      w_trial = '0;
      for (int b = BAL_W - 1; b >= 0; b--) begin
         w_trial = WIDE_W'(w_denom) << b;
         if (WIDE_W'(w_rem) >= w_trial) begin
            w_rem    = w_rem - BAL_W'(w_trial);
            w_quo[b] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res <= '0;
      end else if (i_load) begin
         r_res <= i_value;
      end else if (i_step) begin
         r_res <= w_rem;
      end
   end

   assign o_count_c = w_quo;

endmodule

// File: rtl/vm_multi_item.sv
// Vending-machine controller: config burst, coin accumulation, buy/return decision, serial result window.
module vm_multi_item
   import vm_pkg::*;
#(
   parameter int unsigned NUM_ITEMS = 6,
   parameter int unsigned PRICE_W   = 5,
   parameter int unsigned BAL_W     = 9,
   parameter int unsigned CNT_W     = 6
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_item_valid,
   input  logic [PRICE_W-1:0]                 in_item_price,
   input  logic [CNT_W-1:0]                   in_item_stock,
   input  logic                               in_coin_valid,
   input  logic [5:0]                         in_coin,
   input  logic                               in_rtn_coin,
   input  logic [$clog2(NUM_ITEMS+1)-1:0]     in_buy_item,
   output logic [BAL_W-1:0]                   out_monitor,
   output logic                               out_valid,
   output logic [BAL_W-1:0]                   out_consumer,
   output logic [CNT_W-1:0]                   out_sell_num
);

   localparam int unsigned IDX_W  = $clog2(NUM_ITEMS + 1);
   localparam int unsigned SLOT_W = $clog2(NUM_ITEMS);
   localparam logic [BAL_W-1:0] BAL_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e r_state, w_next;

   logic [PRICE_W-1:0] r_price [NUM_ITEMS];
   logic [CNT_W-1:0]   r_stock [NUM_ITEMS];
   logic [CNT_W-1:0]   r_sell  [NUM_ITEMS];
   logic [BAL_W-1:0]   r_bal;
   logic [BAL_W-1:0]   r_change;
   logic [IDX_W-1:0]   r_item;
   logic [IDX_W-1:0]   r_cfg_idx;
   logic [SLOT_W-1:0]  r_slot;
   logic               r_valid;
   logic [BAL_W-1:0]   r_consumer;
   logic [CNT_W-1:0]   r_sell_out;

   logic [COIN_W-1:0]  w_coin;
   logic [BAL_W:0]     w_sum;
   logic [BAL_W-1:0]   w_bal_add;
   logic               w_coin_en;
   logic               w_cfg_first;
   logic               w_cfg_wr;
   logic [SLOT_W-1:0]  w_cfg_addr;
   logic               w_idx_ok;
   logic [SLOT_W-1:0]  w_sel;
   logic               w_buy_ok;
   logic               w_decide;
   logic               w_last_slot;
   logic [SLOT_W-1:0]  w_next_slot;
   logic               w_cg_step;
   logic [BAL_W-1:0]   w_cg_count;

   // Coin accumulation with saturation; illegal coin values add nothing
   assign w_coin    = is_legal_coin(in_coin) ? in_coin : 6'd0;
   assign w_sum     = {1'b0, r_bal} + (BAL_W + 1)'(w_coin);
   assign w_bal_add = w_sum[BAL_W] ? BAL_MAX : w_sum[BAL_W-1:0];
   assign w_coin_en = in_coin_valid &&
                      ((r_state == ST_COIN) || (r_state == ST_CFG) ||
                       ((r_state == ST_IDLE) && !in_item_valid));

   assign w_cfg_first = (r_state == ST_IDLE) && in_item_valid;
   assign w_cfg_wr    = w_cfg_first ||
                        ((r_state == ST_CFG) && in_item_valid && (r_cfg_idx < IDX_W'(NUM_ITEMS)));
   assign w_cfg_addr  = w_cfg_first ? '0 : SLOT_W'(r_cfg_idx);

   // Buy qualification: index in range, affordable, in stock
   assign w_idx_ok = (in_buy_item != '0) && (in_buy_item <= IDX_W'(NUM_ITEMS));
   assign w_sel    = w_idx_ok ? SLOT_W'(in_buy_item - 1'b1) : '0;
   assign w_buy_ok = w_idx_ok && (BAL_W'(r_price[w_sel]) <= r_bal) && (r_stock[w_sel] != '0);
   assign w_decide = (r_state == ST_COIN) && !in_coin_valid;

   assign w_last_slot = (r_slot == SLOT_W'(NUM_ITEMS - 1));
   assign w_next_slot = SLOT_W'(r_slot + 1'b1);
   assign w_cg_step   = (r_state == ST_OUT) && (r_slot < SLOT_W'(NUM_DENOM));

   vm_change_gen #(.BAL_W(BAL_W)) u_change_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (r_state == ST_DECIDE),
      .i_value   (r_change),
      .i_step    (w_cg_step),
      .i_idx     (3'(r_slot)),
      .o_count_c (w_cg_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (in_item_valid)      w_next = ST_CFG;
            else if (in_coin_valid) w_next = ST_COIN;
         end
         ST_CFG:    if (in_coin_valid) w_next = ST_COIN;
         ST_COIN:   if (!in_coin_valid) w_next = ST_DECIDE;
         ST_DECIDE: w_next = ST_OUT;
         ST_OUT:    if (w_last_slot) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            r_price[i] <= '0;
            r_stock[i] <= '0;
            r_sell[i]  <= '0;
         end
         r_bal      <= '0;
         r_change   <= '0;
         r_item     <= '0;
         r_cfg_idx  <= '0;
         r_slot     <= '0;
         r_valid    <= 1'b0;
         r_consumer <= '0;
         r_sell_out <= '0;
      end else begin
         if (w_cfg_wr) begin
            r_price[w_cfg_addr] <= in_item_price;
            r_stock[w_cfg_addr] <= in_item_stock;
            r_cfg_idx           <= w_cfg_first ? IDX_W'(1) : IDX_W'(r_cfg_idx + 1'b1);
         end
         if (w_cfg_first) begin
            for (int i = 0; i < NUM_ITEMS; i++) r_sell[i] <= '0;
         end
         if (w_coin_en) r_bal <= w_bal_add;

         if (w_decide) begin
            if (in_rtn_coin) begin
               r_change <= r_bal;
               r_item   <= '0;
               r_bal    <= '0;
            end else if (w_buy_ok) begin
               r_change       <= r_bal - BAL_W'(r_price[w_sel]);
               r_item         <= in_buy_item;
               r_bal          <= '0;
               r_stock[w_sel] <= r_stock[w_sel] - 1'b1;
               if (r_sell[w_sel] != CNT_MAX) r_sell[w_sel] <= r_sell[w_sel] + 1'b1;
            end else begin
               r_change <= '0;
               r_item   <= '0;
            end
         end

         // Output window: register the value for the slot presented next cycle
         case (r_state)
            ST_DECIDE: begin
               r_valid    <= 1'b1;
               r_slot     <= '0;
               r_consumer <= BAL_W'(r_item);
               r_sell_out <= r_sell[0];
            end
            ST_OUT: begin
               if (w_last_slot) begin
                  r_valid    <= 1'b0;
                  r_slot     <= '0;
                  r_consumer <= '0;
                  r_sell_out <= '0;
               end else begin
                  r_slot     <= w_next_slot;
                  r_consumer <= w_cg_step ? w_cg_count : '0;
                  r_sell_out <= r_sell[w_next_slot];
               end
            end
            default: begin
               r_valid    <= 1'b0;
               r_consumer <= '0;
               r_sell_out <= '0;
            end
         endcase
      end
   end

   assign out_monitor  = r_bal;
   assign out_valid    = r_valid;
   assign out_consumer = r_consumer;
   assign out_sell_num = r_sell_out;

endmodule
